dvp_pattern_gen: RTL and testbench
==================================

Name: dvp_pattern_gen

Overview:
- Emulates the OV2640 DVP output: produces vsync, href and 10-bit pixel data on ov2640_pixclk, with timing identical to the camera.
- Drives the capture side (downscale/binarize, frame_buffer vin port, MnistLutSimple input) in simulation and in on-board self-test, in place of the sensor.
- Generates selectable synthetic patterns, including a dark box on a white field for exercising the 28x28 binarizer and MNIST path.

Parameters:
- H_ACTIVE, 640: pixels per line with href high.
- H_BLANK, 160: pixclk cycles per line with href low; line period LP = H_ACTIVE+H_BLANK.
- V_SYNC, 3: lines with vsync low at frame start.
- V_BACK, 17: lines with vsync high and href low before active lines.
- V_ACTIVE, 480: active lines.
- V_FRONT, 10: lines with vsync high and href low after active lines.
- BOX_X0, 256: box left edge (pattern 3).
- BOX_Y0, 176: box top edge (pattern 3).
- BOX_W, 128: box width/height (pattern 3).

Ports:
- ov2640_pixclk, input, 1: clock.
- reset, input, 1: reset, asynchronous, active-high.
- enable, input, 1: run request.
- pattern_sel, input, 2: 0 = h-ramp, 1 = v-ramp, 2 = checker, 3 = box.
- vsync, output, 1: high during a frame, low during sync/idle.
- href, output, 1: high during active pixels.
- pixdata, output, 10: pixel value; meaningful only while href=1.
- frame_start, output, 1: one-cycle pulse on the first VSYNC cycle of each frame.
- frame_cnt, output, 16: completed frames.
- busy, output, 1: high whenever state != IDLE.

Behaviour:
- Reset (async): state=IDLE, all counters 0; vsync=0, href=0, pixdata=0, frame_start=0, frame_cnt=0, busy=0.
- All outputs are registered. pixdata is cycle-aligned with href. pixdata is forced to 0 whenever href=0.
- Counters:
  - h counts 0..LP-1 in every non-IDLE state, wrapping to 0.
  - Line counter l advances on h wrap and resets to 0 on each state change.
- FSM:
  - IDLE: vsync=0, href=0. If enable=1 at a clock edge, the next cycle enters VSYNC with h=0, l=0, frame_start=1, and pattern_sel is latched into pat_r.
  - VSYNC: vsync=0. After V_SYNC lines, go to VBACK.
  - VBACK: vsync=1, href=0. After V_BACK lines, go to ACTIVE.
  - ACTIVE: vsync=1, href=1 for h<H_ACTIVE, else 0. Pixel x=h, y=l. After V_ACTIVE lines, go to VFRONT.
  - VFRONT: vsync=1, href=0. On the last cycle, frame_cnt increments (wraps 0xFFFF->0). Next state is VSYNC (new frame, frame_start=1, pattern re-latched) if enable=1, else IDLE.
- A frame is 1..V_SYNC+V_BACK+V_ACTIVE+V_FRONT lines of exactly LP cycles. There are no gaps between back-to-back frames.
- Deasserting enable mid-frame does not truncate the frame; it completes through VFRONT.
- Changing pattern_sel mid-frame has no effect until the next frame start.
- Patterns (x, y are 10-bit; results are truncated to 10 bits):
  - 0 h-ramp: pixdata = x.
  - 1 v-ramp: pixdata = y.
  - 2 checker: pixdata = (x[4]^y[4]) ? 10'h3FF : 10'h000.
  - 3 box: pixdata = 10'h000 if BOX_X0<=x<BOX_X0+BOX_W and BOX_Y0<=y<BOX_Y0+BOX_W, else 10'h3FF.
- Reset asserted mid-frame returns immediately to the reset values. No partial frame_cnt increment occurs.
- Parameter constraints: all values >= 1; H_ACTIVE <= 1024; V_ACTIVE <= 1024.
- Total frame cycles = LP*(V_SYNC+V_BACK+V_ACTIVE+V_FRONT). Defaults give 800*510 = 408000.

Test Plan:
Small-parameter benches use H_ACTIVE=8, H_BLANK=4, V_SYNC=2, V_BACK=1, V_ACTIVE=4, V_FRONT=1, BOX_X0=2, BOX_Y0=1, BOX_W=3 (LP=12, frame=96 cycles).
1. Reset then idle, enable=0 -> vsync=href=busy=frame_start=0 and frame_cnt=0 for 200 cycles.
2. Enable pulsed 1 cycle, pattern 0 -> frame_start high one cycle; vsync low 24 cycles then high 72; href high in 4 bursts of 8 cycles each, starting at cycle 36 (from frame start) with period 12; pixdata 0..7 per burst; frame_cnt=1 after cycle 96; returns to IDLE.
3. enable held high, pattern 3 -> back-to-back frames with no gap; active line y=1 reads 3FF,3FF,000,000,000,3FF,3FF,3FF; line y=0 is all 3FF; frame_cnt=3 after 288 cycles.
4. pattern_sel switched 0->2 mid-frame with enable high -> current frame stays h-ramp; next frame is checker (all 000 at these small sizes since x,y<16).
5. enable dropped during ACTIVE -> frame completes all 4 active lines and VFRONT, then IDLE with busy=0.
6. Async reset asserted mid ACTIVE line -> vsync, href and pixdata go to 0 without a clock edge; frame_cnt unchanged from its pre-frame value is not retained, it reads 0.

Source files
------------

// File: rtl/dvp_pattern_gen.sv
// OV2640-style DVP timing generator with selectable synthetic test patterns.
// Latency: every output is registered and reflects the state/h/l of its own cycle. There is no backpressure; the generator free-runs while busy.
module dvp_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int BOX_X0   = 256,
    parameter int BOX_Y0   = 176,
    parameter int BOX_W    = 128
) (
    input  logic        ov2640_pixclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        vsync,
    output logic        href,
    output logic [9:0]  pixdata,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int LP   = H_ACTIVE + H_BLANK;
    localparam int HW   = $clog2(LP);
    localparam int HWC  = (HW > 10) ? HW : 10;
    localparam int VM01 = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int VM23 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int VMAX = (VM01 > VM23) ? VM01 : VM23;
    localparam int LW   = $clog2(VMAX + 1);
    localparam int LWC  = (LW > 10) ? LW : 10;

    localparam logic [HWC-1:0] H_LAST  = HWC'(LP - 1);
    localparam logic [HWC-1:0] H_ACT_C = HWC'(H_ACTIVE);
    localparam logic [LWC-1:0] L_SYNC_LAST   = LWC'(V_SYNC - 1);
    localparam logic [LWC-1:0] L_BACK_LAST   = LWC'(V_BACK - 1);
    localparam logic [LWC-1:0] L_ACTIVE_LAST = LWC'(V_ACTIVE - 1);
    localparam logic [LWC-1:0] L_FRONT_LAST  = LWC'(V_FRONT - 1);
    localparam logic [31:0] BX0 = 32'(BOX_X0);
    localparam logic [31:0] BX1 = 32'(BOX_X0 + BOX_W);
    localparam logic [31:0] BY0 = 32'(BOX_Y0);
    localparam logic [31:0] BY1 = 32'(BOX_Y0 + BOX_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t         state, state_nxt;
    logic [HWC-1:0] h, h_nxt;
    logic [LWC-1:0] l, l_nxt;
    logic [1:0]     pat_r, pat_nxt;
    logic [LWC-1:0] l_last;
    logic           line_end;
    logic           start_nxt;
    logic           cnt_inc;
    logic           vsync_nxt;
    logic           href_nxt;
    logic [9:0]     pix_nxt;
    logic [9:0]     px;
    logic [9:0]     py;
    logic           in_box;

    always_comb begin
        state_nxt = state;
        h_nxt     = h;
        l_nxt     = l;
        pat_nxt   = pat_r;
        start_nxt = 1'b0;
        cnt_inc   = 1'b0;
        line_end  = (h == H_LAST);

        case (state)
            S_VSYNC:  l_last = L_SYNC_LAST;
            S_VBACK:  l_last = L_BACK_LAST;
            S_ACTIVE: l_last = L_ACTIVE_LAST;
            default:  l_last = L_FRONT_LAST;
        endcase

        if (state == S_IDLE) begin
            if (enable) begin
                state_nxt = S_VSYNC;
                h_nxt     = '0;
                l_nxt     = '0;
                pat_nxt   = pattern_sel;
                start_nxt = 1'b1;
            end
        end else begin
            h_nxt = line_end ? '0 : h + HWC'(1);
            if (line_end) begin
                if (l == l_last) begin
                    l_nxt = '0;
                    case (state)
                        S_VSYNC:  state_nxt = S_VBACK;
                        S_VBACK:  state_nxt = S_ACTIVE;
                        S_ACTIVE: state_nxt = S_VFRONT;
                        default: begin
                            // Frame boundary: either chain straight into the next frame or stop.
                            cnt_inc = 1'b1;
                            if (enable) begin
                                state_nxt = S_VSYNC;
                                pat_nxt   = pattern_sel;
                                start_nxt = 1'b1;
                            end else begin
                                state_nxt = S_IDLE;
                            end
                        end
                    endcase
                end else begin
                    l_nxt = l + LWC'(1);
                end
            end
        end
    end

    // Output values are derived from the next-cycle counters so the registers line up with h/l.
    always_comb begin
        px        = h_nxt[9:0];
        py        = l_nxt[9:0];
        in_box    = ({22'd0, px} >= BX0) && ({22'd0, px} < BX1) &&
                    ({22'd0, py} >= BY0) && ({22'd0, py} < BY1);
        vsync_nxt = (state_nxt == S_VBACK) || (state_nxt == S_ACTIVE) || (state_nxt == S_VFRONT);
        href_nxt  = (state_nxt == S_ACTIVE) && (h_nxt < H_ACT_C);
        pix_nxt   = '0;
        if (href_nxt) begin
            case (pat_nxt)
                2'd0:    pix_nxt = px;
                2'd1:    pix_nxt = py;
                2'd2:    pix_nxt = (px[4] ^ py[4]) ? 10'h3FF : 10'h000;
                default: pix_nxt = in_box ? 10'h000 : 10'h3FF;
            endcase
        end
    end

    always_ff @(posedge ov2640_pixclk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            h           <= '0;
            l           <= '0;
            pat_r       <= '0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            pixdata     <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            h           <= h_nxt;
            l           <= l_nxt;
            pat_r       <= pat_nxt;
            vsync       <= vsync_nxt;
            href        <= href_nxt;
            pixdata     <= pix_nxt;
            frame_start <= start_nxt;
            busy        <= (state_nxt != S_IDLE);
            if (cnt_inc) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// Bench for dvp_pattern_gen with small timing parameters; a frame-time reference model
// predicts every output each cycle while directed and random enable/pattern stimulus is applied.
module tb_dvp_pattern_gen;

    localparam int H_ACTIVE = 8;
    localparam int H_BLANK  = 4;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 1;
    localparam int V_ACTIVE = 4;
    localparam int V_FRONT  = 1;
    localparam int BOX_X0   = 2;
    localparam int BOX_Y0   = 1;
    localparam int BOX_W    = 3;
    localparam int LP       = H_ACTIVE + H_BLANK;
    localparam int FRAME    = LP * (V_SYNC + V_BACK + V_ACTIVE + V_FRONT);

    logic        ov2640_pixclk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        vsync;
    logic        href;
    logic [9:0]  pixdata;
    logic        frame_start;
    logic [15:0] frame_cnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state: whether a frame is running, cycle index within it, latched pattern.
    bit          m_run = 0;
    int          m_t   = 0;
    int          m_pat = 0;
    int          m_cnt = 0;

    dvp_pattern_gen #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .BOX_X0(BOX_X0), .BOX_Y0(BOX_Y0), .BOX_W(BOX_W)
    ) dut (
        .ov2640_pixclk(ov2640_pixclk),
        .reset(reset),
        .enable(enable),
        .pattern_sel(pattern_sel),
        .vsync(vsync),
        .href(href),
        .pixdata(pixdata),
        .frame_start(frame_start),
        .frame_cnt(frame_cnt),
        .busy(busy)
    );

    always #5 ov2640_pixclk = ~ov2640_pixclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
        end
    endtask

    function automatic int pix_model(input int pat, input int x, input int y);
        case (pat)
            0: return x & 10'h3FF;
            1: return y & 10'h3FF;
            2: return (((x / 16) + (y / 16)) % 2 == 1) ? 10'h3FF : 0;
            default: return (x >= BOX_X0 && x < BOX_X0 + BOX_W &&
                             y >= BOX_Y0 && y < BOX_Y0 + BOX_W) ? 0 : 10'h3FF;
        endcase
    endfunction

    task automatic model_edge(input bit en, input int pat);
        if (!m_run) begin
            if (en) begin
                m_run = 1;
                m_t   = 0;
                m_pat = pat;
            end
        end else if (m_t == FRAME - 1) begin
            m_cnt = (m_cnt + 1) % 65536;
            if (en) begin
                m_t   = 0;
                m_pat = pat;
            end else begin
                m_run = 0;
            end
        end else begin
            m_t++;
        end
    endtask

    task automatic compare_all();
        int line, x, y;
        bit e_vs, e_href;
        int e_pix;
        line   = m_t / LP;
        x      = m_t % LP;
        y      = line - (V_SYNC + V_BACK);
        e_vs   = m_run && (line >= V_SYNC);
        e_href = m_run && (y >= 0) && (y < V_ACTIVE) && (x < H_ACTIVE);
        e_pix  = e_href ? pix_model(m_pat, x, y) : 0;
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("href", 32'(href), 32'(e_href));
        chk("pixdata", 32'(pixdata), 32'(e_pix));
        chk("frame_start", 32'(frame_start), 32'(m_run && m_t == 0));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        chk("busy", 32'(busy), 32'(m_run));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            bit en_s;
            int pat_s;
            @(posedge ov2640_pixclk);
            en_s  = enable;
            pat_s = int'(pattern_sel);
            model_edge(en_s, pat_s);
            #1;
            compare_all();
        end
    endtask

    task automatic step_until_t(input int target);
        int budget;
        budget = 4 * FRAME;
        while (!(m_run && m_t == target) && budget > 0) begin
            step(1);
            budget--;
        end
        chk("reach_frame_time", 32'(m_run && m_t == target), 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        #2;
        compare_all();
        @(posedge ov2640_pixclk);
        #2;
        reset = 1'b0;

        // Idle with enable low.
        step(200);

        // Single-cycle enable, h-ramp: one frame then back to idle.
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        step(FRAME + 10);
        chk("single_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("single_frame_idle", 32'(busy), 32'd0);

        // Enable held, box pattern: back-to-back frames.
        pattern_sel = 2'd3;
        enable      = 1'b1;
        step(3 * FRAME + 1);
        chk("b2b_frame_cnt", 32'(frame_cnt), 32'd4);

        // Pattern switched mid-frame only takes effect at the next frame.
        pattern_sel = 2'd0;
        step(FRAME);
        step_until_t(40);
        pattern_sel = 2'd2;
        step(FRAME + 20);

        // Enable dropped during ACTIVE: frame still completes.
        step_until_t(50);
        enable = 1'b0;
        step(FRAME);
        chk("drop_enable_idle", 32'(busy), 32'd0);

        // Randomised enable/pattern activity.
        for (int k = 0; k < 20; k++) begin
            enable      = 1'($urandom_range(0, 1));
            pattern_sel = 2'($urandom_range(0, 3));
            step(int'($urandom_range(1, 60)));
        end
        enable = 1'b0;
        step(FRAME + 5);

        // Asynchronous reset mid active line.
        pattern_sel = 2'd0;
        enable      = 1'b1;
        step_until_t(50);
        #1;
        reset = 1'b1;
        #1;
        m_run = 0;
        m_t   = 0;
        m_cnt = 0;
        chk("arst_vsync", 32'(vsync), 32'd0);
        chk("arst_href", 32'(href), 32'd0);
        chk("arst_pixdata", 32'(pixdata), 32'd0);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        enable = 1'b0;
        #2;
        reset = 1'b0;
        step(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
